// File: rtl/branch_predict_unit.sv
// Resolves branches/jumps from ALU flags, predicts from a PC-indexed bimodal table of
// saturating counters (1-cycle lookup), and counts resolved transfers and mispredicts.
module branch_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int CNT_INIT    = 1,
  parameter int STAT_BITS   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 pred_valid_i,
  input  logic [XLEN-1:0]      pred_pc_i,
  output logic                 pred_taken_o,
  input  logic                 res_valid_i,
  input  logic [XLEN-1:0]      res_pc_i,
  input  logic [2:0]           res_func3_i,
  input  logic [1:0]           res_branch_i,
  input  logic                 res_cf_i,
  input  logic                 res_zf_i,
  input  logic                 res_vf_i,
  input  logic                 res_sf_i,
  input  logic                 res_pred_taken_i,
  output logic                 res_taken_o,
  output logic                 mispredict_o,
  output logic [STAT_BITS-1:0] br_count_o,
  output logic [STAT_BITS-1:0] mispred_count_o
);

  localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
  localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0]  CNT_RST  = CNT_BITS'(CNT_INIT);
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic [CNT_BITS-1:0]  bht_q [BHT_ENTRIES];
  logic                 pred_taken_q, pred_taken_d;
  logic                 mispredict_q, mispredict_d;
  logic [STAT_BITS-1:0] br_count_q, br_count_d;
  logic [STAT_BITS-1:0] mispred_count_q, mispred_count_d;
  logic [CNT_BITS-1:0]  cnt_old, cnt_d;
  logic [IDX_W-1:0]     pred_idx, res_idx;
  logic                 br_cond, f3_legal, upd_en, ctrl_xfer;
  logic                 unused_pc;

  // Word-aligned PCs: bits [1:0] and everything above the index are dropped (aliasing allowed).
  assign pred_idx  = pred_pc_i[IDX_W+1:2];
  assign res_idx   = res_pc_i[IDX_W+1:2];
  assign unused_pc = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0],
                       res_pc_i[XLEN-1:IDX_W+2], res_pc_i[1:0]};

  always_comb begin
    br_cond  = 1'b0;
    f3_legal = 1'b1;
    case (res_func3_i)
      3'b000:  br_cond = res_zf_i;
      3'b001:  br_cond = ~res_zf_i;
      3'b100:  br_cond = res_sf_i != res_vf_i;
      3'b101:  br_cond = res_sf_i == res_vf_i;
      3'b110:  br_cond = ~res_cf_i;
      3'b111:  br_cond = res_cf_i;
      default: f3_legal = 1'b0;
    endcase
  end

  assign res_taken_o = res_branch_i[1] | (res_branch_i[0] & br_cond);
  assign upd_en      = res_valid_i & (res_branch_i == 2'b01) & f3_legal;
  assign ctrl_xfer   = res_valid_i & (res_branch_i != 2'b00);

  always_comb begin
    cnt_old = bht_q[res_idx];
    cnt_d   = cnt_old;
    if (res_taken_o) begin
      if (cnt_old != CNT_MAX) cnt_d = cnt_old + 1'b1;
    end else begin
      if (cnt_old != '0) cnt_d = cnt_old - 1'b1;
    end
  end

  always_comb begin
    pred_taken_d    = pred_valid_i & bht_q[pred_idx][CNT_BITS-1];
    mispredict_d    = ctrl_xfer & (res_taken_o != res_pred_taken_i);
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (ctrl_xfer && br_count_q != STAT_MAX) br_count_d = br_count_q + 1'b1;
    if (mispredict_d && mispred_count_q != STAT_MAX) mispred_count_d = mispred_count_q + 1'b1;
  end

  // Lookup reads bht_q before the same-edge write, giving read-old on index collisions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_RST;
      pred_taken_q    <= 1'b0;
      mispredict_q    <= 1'b0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      if (upd_en) bht_q[res_idx] <= cnt_d;
      pred_taken_q    <= pred_taken_d;
      mispredict_q    <= mispredict_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign pred_taken_o    = pred_taken_q;
  assign mispredict_o    = mispredict_q;
  assign br_count_o      = br_count_q;
  assign mispred_count_o = mispred_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed, table-driven bench for branch_predict_unit: decode vectors plus hand sequences
// for table training, saturation, read-old collision, jumps and mid-update reset.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [2:0]  res_func3;
  logic [1:0]  res_branch;
  logic        res_cf, res_zf, res_vf, res_sf;
  logic        res_pred_taken;
  logic        res_taken;
  logic        mispredict;
  logic [31:0] br_count, mispred_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .pred_valid_i     (pred_valid),
    .pred_pc_i        (pred_pc),
    .pred_taken_o     (pred_taken),
    .res_valid_i      (res_valid),
    .res_pc_i         (res_pc),
    .res_func3_i      (res_func3),
    .res_branch_i     (res_branch),
    .res_cf_i         (res_cf),
    .res_zf_i         (res_zf),
    .res_vf_i         (res_vf),
    .res_sf_i         (res_sf),
    .res_pred_taken_i (res_pred_taken),
    .res_taken_o      (res_taken),
    .mispredict_o     (mispredict),
    .br_count_o       (br_count),
    .mispred_count_o  (mispred_count)
  );

  typedef struct {
    logic [1:0] br;
    logic [2:0] f3;
    logic [3:0] flags;  // {cf, zf, vf, sf}
    logic       exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic [1:0] br,
                         input logic [2:0] f3, input logic [3:0] fl, input logic pt);
    res_valid = v;  res_pc = pc;  res_branch = br;  res_func3 = f3;
    {res_cf, res_zf, res_vf, res_sf} = fl;
    res_pred_taken = pt;
  endtask

  task automatic idle_res();
    set_res(1'b0, 32'h0, 2'b00, 3'b000, 4'b0000, 1'b0);
  endtask

  task automatic lookup(input string nm, input logic [31:0] pc, input logic exp);
    pred_valid = 1'b1;  pred_pc = pc;
    step();
    chk(nm, {31'b0, pred_taken}, {31'b0, exp});
    pred_valid = 1'b0;
  endtask

  // One resolve cycle, then check the registered pulse and both counters.
  task automatic resolve(input string nm, input logic [31:0] pc, input logic [1:0] br,
                         input logic [2:0] f3, input logic [3:0] fl, input logic pt,
                         input logic exp_mp, input int exp_br, input int exp_mis);
    set_res(1'b1, pc, br, f3, fl, pt);
    step();
    chk({nm, "_mp"}, {31'b0, mispredict}, {31'b0, exp_mp});
    chk({nm, "_br"}, br_count, exp_br);
    chk({nm, "_mis"}, mispred_count, exp_mis);
    idle_res();
  endtask

  // Reference decode used for the exhaustive flag sweep.
  function automatic logic ref_taken(input logic [1:0] br, input logic [2:0] f3, input logic [3:0] fl);
    logic cf, zf, vf, sf;
    {cf, zf, vf, sf} = fl;
    if (br[1]) return 1'b1;
    if (!br[0]) return 1'b0;
    case (f3)
      3'b000: return zf;
      3'b001: return !zf;
      3'b100: return sf ^ vf;
      3'b101: return !(sf ^ vf);
      3'b110: return !cf;
      3'b111: return cf;
      default: return 1'b0;
    endcase
  endfunction

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{2'b10, 3'b010, 4'b0000, 1'b1};
    vecs[1]  = '{2'b11, 3'b011, 4'b0000, 1'b1};
    vecs[2]  = '{2'b00, 3'b000, 4'b0100, 1'b0};
    vecs[3]  = '{2'b01, 3'b000, 4'b0100, 1'b1};
    vecs[4]  = '{2'b01, 3'b000, 4'b0000, 1'b0};
    vecs[5]  = '{2'b01, 3'b001, 4'b0000, 1'b1};
    vecs[6]  = '{2'b01, 3'b001, 4'b0100, 1'b0};
    vecs[7]  = '{2'b01, 3'b100, 4'b0001, 1'b1};
    vecs[8]  = '{2'b01, 3'b100, 4'b0011, 1'b0};
    vecs[9]  = '{2'b01, 3'b101, 4'b0011, 1'b1};
    vecs[10] = '{2'b01, 3'b101, 4'b0010, 1'b0};
    vecs[11] = '{2'b01, 3'b110, 4'b0000, 1'b1};
    vecs[12] = '{2'b01, 3'b110, 4'b1000, 1'b0};
    vecs[13] = '{2'b01, 3'b111, 4'b1000, 1'b1};
    vecs[14] = '{2'b01, 3'b010, 4'b1111, 1'b0};
    vecs[15] = '{2'b01, 3'b011, 4'b1111, 1'b0};

    rst = 1'b1;  pred_valid = 1'b0;  pred_pc = '0;
    idle_res();
    step();
    step();
    rst = 1'b0;
    chk("rst_pred", {31'b0, pred_taken}, 32'd0);
    chk("rst_mp", {31'b0, mispredict}, 32'd0);
    chk("rst_br", br_count, 32'd0);
    chk("rst_mis", mispred_count, 32'd0);

    // Hand decode vectors, res_valid low: outcome is purely combinational.
    for (int i = 0; i < 16; i++) begin
      set_res(1'b0, 32'h0, vecs[i].br, vecs[i].f3, vecs[i].flags, 1'b0);
      #1;
      chk($sformatf("vec%0d", i), {31'b0, res_taken}, {31'b0, vecs[i].exp});
    end
    idle_res();

    lookup("init_lookup_100", 32'h100, 1'b0);

    // Train 0x100 (idx 0) taken twice: 1 -> 2 -> 3.
    set_res(1'b1, 32'h100, 2'b01, 3'b000, 4'b0100, 1'b0);
    #1 chk("beq_taken_comb", {31'b0, res_taken}, 32'd1);
    resolve("beq1", 32'h100, 2'b01, 3'b000, 4'b0100, 1'b0, 1'b1, 1, 1);
    resolve("beq2", 32'h100, 2'b01, 3'b000, 4'b0100, 1'b0, 1'b1, 2, 2);
    step();
    chk("mp_not_sticky", {31'b0, mispredict}, 32'd0);
    lookup("trained_100", 32'h100, 1'b1);
    // Top saturation: 3 stays 3, then one not-taken leaves 2 (MSB still set).
    resolve("beq_sat", 32'h100, 2'b01, 3'b000, 4'b0100, 1'b1, 1'b0, 3, 2);
    resolve("beq_nt", 32'h100, 2'b01, 3'b000, 4'b0000, 1'b1, 1'b1, 4, 3);
    lookup("sat_hi_100", 32'h100, 1'b1);

    // 0x104 (idx 1): up to 3, then five not-taken floor at 0, one taken gives 1.
    resolve("bne_t1", 32'h104, 2'b01, 3'b001, 4'b0000, 1'b1, 1'b0, 5, 3);
    resolve("bne_t2", 32'h104, 2'b01, 3'b001, 4'b0000, 1'b1, 1'b0, 6, 3);
    lookup("trained_104", 32'h104, 1'b1);
    for (int k = 0; k < 5; k++)
      resolve($sformatf("bne_nt%0d", k), 32'h104, 2'b01, 3'b001, 4'b0100, 1'b1, 1'b1, 7 + k, 4 + k);
    lookup("floor_104", 32'h104, 1'b0);
    resolve("bne_up", 32'h104, 2'b01, 3'b001, 4'b0000, 1'b1, 1'b0, 12, 8);
    lookup("no_wrap_104", 32'h104, 1'b0);

    // JAL: always taken, counted, table untouched (idx 1 stays 1).
    set_res(1'b1, 32'h104, 2'b10, 3'b010, 4'b0000, 1'b0);
    #1 chk("jal_taken_comb", {31'b0, res_taken}, 32'd1);
    resolve("jal", 32'h104, 2'b10, 3'b010, 4'b0000, 1'b0, 1'b1, 13, 9);
    lookup("jal_no_upd", 32'h104, 1'b0);
    resolve("none", 32'h104, 2'b00, 3'b000, 4'b0100, 1'b1, 1'b0, 13, 9);
    resolve("illegal_f3", 32'h104, 2'b01, 3'b010, 4'b0000, 1'b1, 1'b1, 14, 10);

    // 0x200 aliases idx 0 (counter 2): one not-taken brings it to 1.
    resolve("alias_nt", 32'h200, 2'b01, 3'b000, 4'b0000, 1'b0, 1'b0, 15, 10);
    lookup("alias_200", 32'h200, 1'b0);
    // Same-cycle lookup and taken update: read-old then new value.
    pred_valid = 1'b1;  pred_pc = 32'h200;
    set_res(1'b1, 32'h200, 2'b01, 3'b000, 4'b0100, 1'b0);
    step();
    chk("readold_pred", {31'b0, pred_taken}, 32'd0);
    chk("readold_mp", {31'b0, mispredict}, 32'd1);
    chk("readold_br", br_count, 32'd16);
    chk("readold_mis", mispred_count, 32'd11);
    idle_res();
    step();
    chk("readnew_pred", {31'b0, pred_taken}, 32'd1);
    pred_valid = 1'b0;

    // Exhaustive decode sweep for all branch types.
    for (int b = 1; b < 4; b++)
      for (int f = 0; f < 8; f++)
        for (int fl = 0; fl < 16; fl++) begin
          set_res(1'b0, 32'h0, 2'(b), 3'(f), 4'(fl), 1'b0);
          #1;
          chk($sformatf("sweep_b%0d_f%0d_fl%0h", b, f, fl), {31'b0, res_taken},
              {31'b0, ref_taken(2'(b), 3'(f), 4'(fl))});
        end
    idle_res();

    // Reset during a taken update at 0x104 (counter raised to 2 first) discards it.
    resolve("pre_rst", 32'h104, 2'b01, 3'b001, 4'b0000, 1'b1, 1'b0, 17, 11);
    lookup("pre_rst_104", 32'h104, 1'b1);
    set_res(1'b1, 32'h104, 2'b01, 3'b001, 4'b0000, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_res();
    chk("mid_rst_mp", {31'b0, mispredict}, 32'd0);
    chk("mid_rst_br", br_count, 32'd0);
    chk("mid_rst_mis", mispred_count, 32'd0);
    lookup("mid_rst_104", 32'h104, 1'b0);
    lookup("mid_rst_100", 32'h100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the EX-stage branch decision logic. Resolves conditional branches and jumps from ALU flags (cf/zf/vf/sf) and func3. Adds a PC-indexed bimodal branch-history table of saturating counters, which gives IF a one-cycle-latency taken prediction. Also flags mispredictions and keeps branch and mispredict statistics. Sits between IF (lookup) and EX (resolve/update).

Parameters:
XLEN, 32, PC width
BHT_ENTRIES, 64, table depth; power of two, >= 2
CNT_BITS, 2, saturating counter width; >= 1
CNT_INIT, 1, reset value of every counter (weakly not-taken for 2 bits); < 2^CNT_BITS
STAT_BITS, 32, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset
pred_valid  in  1  IF lookup request
pred_pc  in  XLEN  PC of fetched instruction
pred_taken  out  1  registered prediction for the previous cycle's lookup
res_valid  in  1  EX resolution strobe
res_pc  in  XLEN  PC of the resolving instruction
res_func3  in  3  branch func3
res_branch  in  2  [1] unconditional jump, [0] conditional branch
res_cf, res_zf, res_vf, res_sf  in  1 each  ALU flags
res_pred_taken  in  1  prediction carried down the pipe with this instruction
res_taken  out  1  combinational actual outcome
mispredict  out  1  registered mispredict pulse
br_count  out  STAT_BITS  resolved control-transfer count
mispred_count  out  STAT_BITS  mispredict count

Behaviour:
- Reset is synchronous and active-high on rst. It acts on the clk rising edge when rst=1.
- At reset: all BHT_ENTRIES counters load CNT_INIT; pred_taken=0, mispredict=0, br_count=0, mispred_count=0.
- Reset asserted mid-operation discards any update presented that cycle.
- Index = pc[log2(BHT_ENTRIES)+1:2]. Upper PC bits are ignored, so aliasing is permitted.
- res_taken is combinational:
  - res_branch[1]=1: res_taken=1, regardless of func3 or res_branch[0].
  - Else if res_branch[0]=1, decode func3:
    - 000 BEQ: zf
    - 001 BNE: ~zf
    - 100 BLT: sf!=vf
    - 101 BGE: sf==vf
    - 110 BLTU: ~cf
    - 111 BGEU: cf
    - 010/011: 0
  - Else: res_taken=0.
  - res_taken does not depend on res_valid.
- Lookup: on each clk, pred_taken <= pred_valid ? counter[idx(pred_pc)][CNT_BITS-1] : 0. Latency is 1 cycle.
- Update happens when res_valid=1, res_branch=01 and func3 is legal:
  - taken: counter = min(counter+1, 2^CNT_BITS-1)
  - not taken: counter = max(counter-1, 0)
  - Counters saturate and never wrap.
- Jumps (res_branch[1]=1) and illegal func3 do not touch the table.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update counter (read-old). The write lands at the same edge.
- mispredict <= res_valid & (res_branch!=00) & (res_taken != res_pred_taken). It is a one-cycle pulse and is not sticky.
- br_count increments when res_valid & res_branch!=00.
- mispred_count increments on the same condition as mispredict, in the same edge.
- Both statistics counters saturate at 2^STAT_BITS-1.
- res_valid=1 with res_branch=00: no update, no count, mispredict=0.

Test Plan:
1. Reset, then lookup pc=0x100 -> pred_taken=0 next cycle (CNT_INIT=1, MSB 0); all stats 0.
2. Resolve BEQ at pc=0x100 with zf=1 twice, res_pred_taken=0 -> mispredict pulses twice, counter goes 1->2->3. Lookup of 0x100 then gives pred_taken=1. mispred_count=2, br_count=2.
3. Four not-taken BNE (zf=1) at pc=0x104 from counter 3 -> counter ends at 0 and stays 0 on a fifth. Lookup returns 0.
4. JAL (res_branch=10, func3=010, res_pred_taken=0) -> res_taken=1, mispredict=1, br_count+1, table unchanged. res_branch=00 -> no count.
5. Same-cycle lookup and taken update at pc=0x200 with counter=1 -> pred_taken=0 that cycle. The following lookup gives 1.
6. Flag sweep of all 8 func3 x 16 flag combinations -> res_taken matches the decode above. Also assert rst during an update -> counter equals CNT_INIT next cycle.
